// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller:
// the scan state encoding and a width helper.
package seven_seg_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,
      SCAN_BLANK = 2'd1,
      SCAN_SHOW  = 2'd2
   } scan_state_t;

   // Bits needed to hold the values 0 .. n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Control, load and display signal bundle between a host and the
// seven-segment scan controller.
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    lz_suppress;
   logic                    load_ack;
   logic [3:0]              digit_data;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic                    dp_n;
   logic                    blank;
   logic                    frame_done;

   modport master (
      output enable, load, value, dp_in, lz_suppress,
      input  load_ack, digit_data, digit_sel, dp_n, blank, frame_done
   );

   modport slave (
      input  enable, load, value, dp_in, lz_suppress,
      output load_ack, digit_data, digit_sel, dp_n, blank, frame_done
   );
endinterface

// File: rtl/seven_seg_slot_timer.sv
// Digit slot prescaler: counts 0 .. PRESCALE-1 per slot and flags the
// last blanking cycle and the last cycle of the slot.
module seven_seg_slot_timer
   import seven_seg_scan_ctrl_pkg::*;
#(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,
   input  logic i_clear,
   output logic o_blank_end,
   output logic o_slot_end
);
   localparam int CNT_W = clog2(PRESCALE);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_count;

   assign o_blank_end = (r_count == BLANK_LAST);
   assign o_slot_end  = (r_count == SLOT_LAST);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_run) begin
         r_count <= o_slot_end ? '0 : r_count + 1'b1;
      end
   end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits
// sharing one hex decoder; value/dp are double-buffered and swap per frame.
//
//   state      | meaning
//   SCAN_IDLE  | scanning disabled, all digits off, pending commits every edge
//   SCAN_BLANK | first BLANK_CYCLES of a slot, digits off while decoder settles
//   SCAN_SHOW  | rest of the slot, digit r_idx enabled unless suppressed
module seven_seg_scan_ctrl
   import seven_seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   seven_seg_scan_ctrl_if.slave bus
);
   localparam int IDX_W = clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   scan_state_t             r_state;
   scan_state_t             w_state_nxt;
   logic [IDX_W-1:0]        r_idx;
   logic [IDX_W-1:0]        w_idx_nxt;
   logic [4*NUM_DIGITS-1:0] r_shadow_val;
   logic [4*NUM_DIGITS-1:0] r_pend_val;
   logic [NUM_DIGITS-1:0]   r_shadow_dp;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic                    r_pend_valid;
   logic                    r_load_ack;

   logic                    w_blank_end;
   logic                    w_slot_end;
   logic                    w_run;
   logic                    w_clear;
   logic                    w_frame_bnd;
   logic                    w_suppress;
   logic                    w_dp_sel;
   logic [3:0]              w_nibble;
   logic [IDX_W-1:0]        w_top_idx;

   assign w_run   = (r_state != SCAN_IDLE);
   assign w_clear = ~bus.enable;

   seven_seg_slot_timer #(
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_slot_timer (
      .clk         (clk),
      .rst         (rst),
      .i_run       (w_run),
      .i_clear     (w_clear),
      .o_blank_end (w_blank_end),
      .o_slot_end  (w_slot_end)
   );

   // Current digit's nibble/dp and the highest nonzero digit for suppression.
   always_comb begin
      w_nibble  = 4'h0;
      w_dp_sel  = 1'b0;
      w_top_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nibble = r_shadow_val[4*i +: 4];
            w_dp_sel = r_shadow_dp[i];
         end
         if (r_shadow_val[4*i +: 4] != 4'h0) begin
            w_top_idx = IDX_W'(i);
         end
      end
   end

   assign w_suppress     = bus.lz_suppress && (r_idx > w_top_idx);
   assign bus.digit_data = w_nibble;
   assign bus.load_ack   = r_load_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SCAN_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_frame_bnd    = (r_state == SCAN_IDLE);
      bus.digit_sel  = '1;
      bus.blank      = 1'b1;
      bus.dp_n       = 1'b1;
      bus.frame_done = 1'b0;

      if (!bus.enable) begin
         w_state_nxt = SCAN_IDLE;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            SCAN_IDLE: begin
               w_state_nxt = SCAN_BLANK;
               w_idx_nxt   = '0;
            end
            SCAN_BLANK: begin
               if (w_blank_end) begin
                  w_state_nxt = SCAN_SHOW;
               end
            end
            SCAN_SHOW: begin
               if (w_slot_end) begin
                  w_state_nxt = SCAN_BLANK;
                  if (r_idx == IDX_LAST) begin
                     w_idx_nxt   = '0;
                     w_frame_bnd = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = SCAN_IDLE;
               w_idx_nxt   = '0;
            end
         endcase
      end

      if (r_state == SCAN_SHOW) begin
         bus.frame_done = w_slot_end && (r_idx == IDX_LAST);
         if (!w_suppress) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               bus.digit_sel[i] = (r_idx != IDX_W'(i));
            end
            bus.blank = 1'b0;
            bus.dp_n  = ~w_dp_sel;
         end
      end
   end

   // A load on a commit edge lands in pending after the old pending moves up.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_pend_val   <= '0;
         r_pend_dp    <= '0;
         r_pend_valid <= 1'b0;
         r_load_ack   <= 1'b0;
      end else begin
         r_load_ack <= bus.load;
         if (w_frame_bnd) begin
            r_pend_valid <= 1'b0;
            if (r_pend_valid) begin
               r_shadow_val <= r_pend_val;
               r_shadow_dp  <= r_pend_dp;
            end
         end
         if (bus.load) begin
            r_pend_val   <= bus.value;
            r_pend_dp    <= bus.dp_in;
            r_pend_valid <= 1'b1;
         end
      end
   end
endmodule
